// File: rtl/layer_out_serializer_pkg.sv
// Shared definitions for the layer output serializer: default widths,
// the streamer state encoding and the lane-index width helper.
package layer_out_serializer_pkg;

   localparam int NN_DEF         = 30;
   localparam int DATA_WIDTH_DEF = 16;

   // Lane index width; a single lane still needs one index bit.
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int IDX_W_DEF = idx_width(NN_DEF);

   // Streamer states: IDLE waits for a full bank, RUN emits one word per cycle.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } stream_state_t;

endpackage : layer_out_serializer_pkg

// File: rtl/layer_capture_bank.sv
// Capture bank: holds one word per lane plus a "held" flag per lane.
// Reports full once every lane is held and raises a sticky overflow when a
// lane fires again before its held word has been transferred out.
// On the transfer edge the bank is handed over and lanes firing in that same
// cycle land in the freshly emptied bank without counting as overflow.
module layer_capture_bank
   import layer_out_serializer_pkg::*;
#(
   parameter int NN         = NN_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NN-1:0]              x_valid,
   input  logic [NN*DATA_WIDTH-1:0]   x_in,
   input  logic                       xfer,
   output logic [NN*DATA_WIDTH-1:0]   bank,
   output logic                       full,
   output logic                       any_flag,
   output logic                       overflow
);

   logic [NN-1:0] flag_q;
   logic [NN-1:0] flag_d;
   logic [NN-1:0] load;
   logic          ovf_hit;

   // Next flags, per-lane load enables and overflow detection.
   always_comb begin
      flag_d  = flag_q;
      load    = '0;
      ovf_hit = 1'b0;
      if (xfer) begin
         flag_d = x_valid;
         load   = x_valid;
      end else begin
         flag_d  = flag_q | x_valid;
         load    = x_valid & ~flag_q;
         ovf_hit = |(x_valid & flag_q);
      end
   end

   // Flag, full and sticky overflow registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_q   <= '0;
         full     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         flag_q <= flag_d;
         full   <= &flag_d;
         if (ovf_hit) begin
            overflow <= 1'b1;
         end
      end
   end

   // Lane data registers; a held word is never overwritten before transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank <= '0;
      end else begin
         for (int k = 0; k < NN; k++) begin
            if (load[k]) begin
               bank[k*DATA_WIDTH +: DATA_WIDTH] <= x_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   assign any_flag = |flag_q;

endmodule : layer_capture_bank

// File: rtl/layer_out_serializer.sv
// Layer output serializer: gathers NN lane words from the upstream layer,
// then broadcasts them one per cycle, lane 0 first. A second set can be
// captured while the first streams; when it is complete by the time the
// last word goes out, the next burst follows with no idle cycle.
// Stream handshake: o_valid marks a word on o_data every cycle it is high;
// there is no ready, the consumer must take every word it is offered.
module layer_out_serializer
   import layer_out_serializer_pkg::*;
#(
   parameter int NN         = NN_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int IDX_W      = $clog2(NN)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NN-1:0]            x_valid,
   input  logic [NN*DATA_WIDTH-1:0] x_in,
   output logic [DATA_WIDTH-1:0]    o_data,
   output logic                     o_valid,
   output logic                     o_last,
   output logic [IDX_W-1:0]         o_idx,
   output logic                     busy,
   output logic                     overflow
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

   stream_state_t               state_q;
   stream_state_t               state_d;
   logic [IDX_W-1:0]            idx_q;
   logic [DATA_WIDTH-1:0]       shift_q [NN];
   logic [NN*DATA_WIDTH-1:0]    bank;
   logic                        full;
   logic                        any_flag;
   logic                        xfer;
   logic                        last_word;

   layer_capture_bank #(
      .NN         (NN),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_capture (
      .clk      (clk),
      .rst      (rst),
      .x_valid  (x_valid),
      .x_in     (x_in),
      .xfer     (xfer),
      .bank     (bank),
      .full     (full),
      .any_flag (any_flag),
      .overflow (overflow)
   );

   // Streamer state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Transfer decision and next state; a transfer on the last word keeps RUN.
   always_comb begin
      state_d   = state_q;
      last_word = (state_q == ST_RUN) && (idx_q == LAST_IDX);
      xfer      = full && ((state_q == ST_IDLE) || last_word);
      case (state_q)
         ST_IDLE: if (xfer) state_d = ST_RUN;
         ST_RUN:  if (last_word && !xfer) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Lane index: restarts on transfer, steps through the burst, rests at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
      end else if (xfer) begin
         idx_q <= '0;
      end else if (state_q == ST_RUN) begin
         idx_q <= last_word ? '0 : idx_q + IDX_W'(1);
      end
   end

   // Shift bank: snapshot of the capture bank taken on transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NN; k++) begin
            shift_q[k] <= '0;
         end
      end else if (xfer) begin
         for (int k = 0; k < NN; k++) begin
            shift_q[k] <= bank[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign o_valid = (state_q == ST_RUN);
   assign o_data  = o_valid ? shift_q[idx_q] : '0;
   assign o_idx   = idx_q;
   assign o_last  = last_word;
   assign busy    = any_flag | full | (state_q == ST_RUN);

endmodule : layer_out_serializer

// File: tb/tb_layer_out_serializer.sv
// Bench for layer_out_serializer with four lanes. Expected words are queued
// as {lane, data} when a lane set is driven and checked as the stream emits.
module tb_layer_out_serializer;

   localparam int NN = 4;
   localparam int DW = 16;
   localparam int IW = 2;
   localparam int EW = IW + DW;

   logic              clk;
   logic              rst;
   logic [NN-1:0]     x_valid;
   logic [NN*DW-1:0]  x_in;
   logic [DW-1:0]     o_data;
   logic              o_valid;
   logic              o_last;
   logic [IW-1:0]     o_idx;
   logic              busy;
   logic              overflow;

   logic [EW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   layer_out_serializer #(
      .NN         (NN),
      .DATA_WIDTH (DW),
      .IDX_W      (IW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .x_valid  (x_valid),
      .x_in     (x_in),
      .o_data   (o_data),
      .o_valid  (o_valid),
      .o_last   (o_last),
      .o_idx    (o_idx),
      .busy     (busy),
      .overflow (overflow)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (!rst && o_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream_unexpected: got lane %0d data %h, expected no word", o_idx, o_data);
         end else begin
            e = exp_q.pop_front();
            if ({o_idx, o_data} !== e || o_last !== (e[EW-1:DW] == IW'(NN-1))) begin
               errors++;
               $display("FAIL stream_word: got lane %0d data %h last %b, expected lane %0d data %h last %b",
                        o_idx, o_data, o_last, e[EW-1:DW], e[DW-1:0], (e[EW-1:DW] == IW'(NN-1)));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic [NN*DW-1:0] pack4(input logic [DW-1:0] w0, w1, w2, w3);
      return {w3, w2, w1, w0};
   endfunction

   task automatic drive(input logic [NN-1:0] v, input logic [NN*DW-1:0] d);
      x_valid = v;
      x_in    = d;
      @(posedge clk);
      #1;
      x_valid = '0;
   endtask

   task automatic push_set(input logic [NN*DW-1:0] d);
      for (int k = 0; k < NN; k++) begin
         exp_q.push_back({IW'(k), d[k*DW +: DW]});
      end
   endtask

   // Counts edges until o_valid is seen just after an edge (bounded).
   task automatic wait_valid(output int edges);
      edges = 0;
      while (edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
         if (o_valid) break;
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle: busy %b after %0d cycles, expected 0", name, busy, n);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      x_valid = '0;
      x_in = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({o_valid, o_last, o_idx, o_data, busy, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got v%b l%b i%0d d%h b%b o%b, expected all 0",
                  o_valid, o_last, o_idx, o_data, busy, overflow);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      int edges;
      push_set(pack4(16'h0011, 16'h0022, 16'h0033, 16'h0044));
      drive(4'b1111, pack4(16'h0011, 16'h0022, 16'h0033, 16'h0044));
      checks++;
      if (o_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_after_capture: got valid %b busy %b, expected valid 0 busy 1", o_valid, busy);
      end
      wait_valid(edges);
      checks++;
      if (edges !== 1) begin
         errors++;
         $display("FAIL single_latency: got %0d extra edges, expected 1", edges);
      end
      for (int c = 1; c < NN; c++) begin
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      checks++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_burst_len: o_valid %b after %0d words, expected 0", o_valid, NN);
      end
      wait_idle("single");
   endtask

   task automatic test_staggered();
      int edges;
      logic [NN*DW-1:0] d;
      int order [NN] = '{2, 0, 3, 1};
      d = pack4(16'h1000, 16'h1111, 16'h1222, 16'h1333);
      push_set(d);
      for (int i = 0; i < NN; i++) begin
         drive(NN'(1) << order[i], d);
         checks++;
         if (o_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stagger_step%0d: got valid %b busy %b, expected valid 0 busy 1", i, o_valid, busy);
         end
      end
      wait_valid(edges);
      checks++;
      if (edges !== 1) begin
         errors++;
         $display("FAIL stagger_latency: got %0d extra edges, expected 1", edges);
      end
      wait_idle("stagger");
   endtask

   task automatic test_back_to_back();
      int edges;
      int run_len = 0;
      logic [NN*DW-1:0] a;
      logic [NN*DW-1:0] b;
      for (int k = 0; k < NN; k++) begin
         a[k*DW +: DW] = DW'($urandom_range(0, 16'hFFFF));
         b[k*DW +: DW] = DW'($urandom_range(0, 16'hFFFF));
      end
      push_set(a);
      drive(4'b1111, a);
      wait_valid(edges);
      push_set(b);
      drive(4'b1111, b);
      run_len = 2;
      while (o_valid && run_len < 20) begin
         @(posedge clk);
         #1;
         if (o_valid) run_len++;
      end
      checks++;
      if (run_len !== 2 * NN) begin
         errors++;
         $display("FAIL b2b_run_length: got %0d consecutive words, expected %0d", run_len, 2 * NN);
      end
      wait_idle("b2b");
   endtask

   task automatic test_overflow();
      int edges;
      push_set(pack4(16'h0C00, 16'h0AAA, 16'h0C22, 16'h0C33));
      drive(4'b0010, pack4(16'h0, 16'h0AAA, 16'h0, 16'h0));
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_first_write: got overflow %b, expected 0", overflow);
      end
      drive(4'b0010, pack4(16'h0, 16'h0BBB, 16'h0, 16'h0));
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set: got overflow %b, expected 1", overflow);
      end
      drive(4'b1101, pack4(16'h0C00, 16'h0DDD, 16'h0C22, 16'h0C33));
      wait_valid(edges);
      wait_idle("ovf");
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: got overflow %b, expected 1", overflow);
      end
   endtask

   task automatic test_reset_mid_stream();
      int n = 0;
      push_set(pack4(16'h5500, 16'h5511, 16'h5522, 16'h5533));
      drive(4'b1111, pack4(16'h5500, 16'h5511, 16'h5522, 16'h5533));
      do begin
         @(negedge clk);
         n++;
      end while (!(o_valid && o_idx == 2) && n < 20);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({o_valid, o_last, busy, overflow, o_idx, o_data} !== '0) begin
         errors++;
         $display("FAIL midrst_async: got v%b l%b b%b o%b i%0d d%h, expected all 0",
                  o_valid, o_last, busy, overflow, o_idx, o_data);
      end
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         checks++;
         if (o_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet: got valid %b busy %b, expected 0 0", o_valid, busy);
         end
      end
   endtask

   task automatic test_capture_during_transfer();
      int edges;
      int run_len;
      logic [NN*DW-1:0] a;
      logic [NN*DW-1:0] b;
      a = pack4(16'h7700, 16'h7711, 16'h7722, 16'h7733);
      b = pack4(16'h8800, 16'h8811, 16'h8822, 16'h8833);
      push_set(a);
      push_set(b);
      drive(4'b1111, a);
      drive(4'b0001, b);
      checks++;
      if (o_valid !== 1'b1 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL xfer_capture: got valid %b overflow %b, expected 1 0", o_valid, overflow);
      end
      drive(4'b1110, b);
      run_len = 2;
      while (o_valid && run_len < 20) begin
         @(posedge clk);
         #1;
         if (o_valid) run_len++;
      end
      checks++;
      if (run_len !== 2 * NN || overflow !== 1'b0) begin
         errors++;
         $display("FAIL xfer_follow: got %0d words overflow %b, expected %0d words overflow 0",
                  run_len, overflow, 2 * NN);
      end
      wait_idle("xfer");
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single();
      test_staggered();
      test_back_to_back();
      test_overflow();
      test_reset_mid_stream();
      test_capture_during_transfer();
      repeat (3) @(posedge clk);
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d words never emitted, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_layer_out_serializer

// File: doc/layer_out_serializer.md
Name: layer_out_serializer

Overview:
- Sits directly downstream of a neuron layer.
- Collects the NN parallel 16-bit neuron outputs. Each output comes with its own valid pulse, and the pulses may arrive in different cycles.
- Once all NN outputs are held, it streams them out one word per cycle, neuron 0 first. This serial stream is broadcast as the input of the next layer.
- Double-buffered: the next set of outputs can be collected while the previous set is still streaming.

Parameters:
- NN, 30, number of neurons in the upstream layer (lanes); must be ≥ 2
- DATA_WIDTH, 16, width of one neuron output word
- IDX_W, $clog2(NN), width of the lane index

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- x_valid  input  NN  per-lane valid pulse from upstream layer o_valid
- x_in  input  NN*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- o_data  output  DATA_WIDTH  current serial word
- o_valid  output  1  o_data valid this cycle
- o_last  output  1  high with the word for lane NN-1
- o_idx  output  IDX_W  lane index of the current word
- busy  output  1  capture bank partially or fully loaded, or stream running
- overflow  output  1  sticky error flag, cleared only by rst

Behaviour:
- Reset (asynchronous, rst=1):
  - Clears all capture flags and the full flag.
  - Stream stops; the index counter returns to 0.
  - Outputs: o_valid=0, o_last=0, o_idx=0, o_data=0, busy=0, overflow=0.
  - Data registers are also cleared.
  - Reset in the middle of a stream aborts it. The next o_valid requires a complete fresh capture.
- Capture bank:
  - NN data registers plus NN flags.
  - When x_valid[k]=1 and flag[k]=0 on a clock edge: store lane k and set flag[k].
  - When x_valid[k]=1 and flag[k]=1 (lane already held, not yet transferred): the new word is dropped, the held word is kept, and overflow is set.
  - full is a registered signal, set on the edge after all flags are 1.
- Transfer:
  - Occurs on an edge where full=1 and the streamer is IDLE or presenting its last word (o_last=1).
  - Copies the capture bank into the shift bank.
  - Clears all flags and full.
  - Sets the index to 0 and the streamer to RUN.
  - Any x_valid[k] in the transfer cycle is captured into the freshly cleared bank: the flag is set and no overflow is raised.
- Streamer FSM:
  - IDLE → RUN on transfer.
  - RUN: o_valid=1, o_data = shift bank[idx], o_idx=idx, o_last = (idx==NN-1).
  - Index increments on each edge while in RUN.
  - RUN → IDLE after the word for lane NN-1, unless a transfer occurs on that same edge. In that case it stays in RUN with idx=0, giving a gap-free stream.
- There is no backpressure; downstream must accept one word per cycle.
- Latency:
  - Last lane valid sampled at edge E0 → full=1 after E0 → transfer at E1 → first o_valid high after E1.
  - A burst is exactly NN consecutive cycles.
- busy = (any flag) | full | RUN.
- All outputs are registered or decoded directly from registers; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package holds:
  - DATA_WIDTH default
  - the streamer state enum (IDLE, RUN)
  - a clog2-based index-width constant
- One natural sub-module: layer_capture_bank.
  - Contains the NN data and flag registers, the full flag and the overflow detection.
  - Interface: a transfer strobe in, the parallel bank and full out.
- The streamer FSM stays in the top level.

Test Plan:
- Single-cycle capture, NN=4, data {0x0011,0x0022,0x0033,0x0044}:
  - Stimulus: x_valid=4'b1111 for one cycle.
  - Response: after 2 edges, o_valid high for 4 cycles with o_data 0x0011, 0x0022, 0x0033, 0x0044; o_last only on 0x0044; o_idx 0..3.
- Staggered valids:
  - Stimulus: lanes 2, 0, 3, 1 valid in separate cycles.
  - Response: no o_valid until 2 edges after lane 1; order is still by lane index.
- Back-to-back sets:
  - Stimulus: second full set arrives while the first is streaming.
  - Response: 8 consecutive o_valid cycles with no gap; second set's data follows the first's o_last.
- Overflow:
  - Stimulus: lane 1 valid twice (0x0AAA then 0x0BBB) before lanes 0, 2 and 3 arrive.
  - Response: overflow=1 and stays high; stream emits 0x0AAA for lane 1.
- Reset mid-stream:
  - Stimulus: assert rst during idx=2.
  - Response: o_valid, o_last, busy and overflow all go to 0 immediately (asynchronous); nothing is emitted until a new full set is captured.
- Capture during transfer:
  - Stimulus: lane 0 valid on the transfer edge.
  - Response: flag[0] is set in the new bank, overflow stays 0, and the word appears in the next burst.
